id_ex_stage: RTL and testbench
==============================

# id_ex_stage

ID/EX pipeline register for the five-stage pipelined CPU, sitting directly downstream of the register file's combinational read ports. It captures the decoded instruction, its operands and its control bundle into the EX stage. It fixes the register file's same-cycle write/read hazard by bypassing writeback data. It also detects load-use hazards, raising a stall and inserting a bubble.

## Interface
Parameters:
- `CTRL_W`, 10 — control bundle width: {RegWrite, MemRead, MemWrite, MemToReg, ALUSrc, RegDst, ALUOp[3:0]}, MSB first
- `CNT_W`, 16 — stall performance counter width

Ports:
- `CLK` in 1 — clock; all state updates on posedge
- `RST_N` in 1 — asynchronous, active-low reset
- `ID_Valid` in 1 — decode slot holds a real instruction
- `ID_PC` in 32 — PC of the decode instruction
- `ID_Rs`, `ID_Rt`, `ID_Rd` in 5 each — register specifiers
- `ID_UsesRs`, `ID_UsesRt` in 1 each — instruction actually reads that source
- `ID_Imm` in 32 — sign-extended immediate
- `ID_Ctrl` in CTRL_W — decoded control bundle
- `register1`, `register2` in 32 — register file read data for Rs/Rt
- `WB_RegWrite` in 1, `WB_Write` in 5, `WB_WriteData` in 32 — the same writeback signals driving the register file
- `Flush` in 1 — discard the decode instruction (taken branch/jump)
- `Stall` out 1 — combinational; holds PC and IF/ID this cycle
- `EX_Valid` out 1; `EX_PC` out 32; `EX_A`, `EX_B` out 32; `EX_Imm` out 32
- `EX_Rs`, `EX_Rt`, `EX_Dest` out 5; `EX_Ctrl` out CTRL_W
- `StallCount` out CNT_W — saturating count of stall cycles

## Operation
- Bypass: `opA = (WB_RegWrite && WB_Write!=0 && WB_Write==ID_Rs) ? WB_WriteData : register1`. `opB` uses the same rule with `ID_Rt`/`register2`.
- Load-use hazard: `haz = ID_Valid && EX_Valid && EX_Ctrl.MemRead && EX_Rt!=0 && ((ID_UsesRs && ID_Rs==EX_Rt) || (ID_UsesRt && ID_Rt==EX_Rt))`.
- `Stall = haz && !Flush`. A flush discards the instruction, so there is no reason to stall.
- Per posedge, in priority order:
  - Flush or haz: load a bubble. `EX_Valid=0`, `EX_Ctrl=0`, all other EX fields 0.
  - Otherwise: capture the decode slot. `EX_Valid=ID_Valid`. `EX_Ctrl=ID_Valid ? ID_Ctrl : 0`. `EX_A=opA`, `EX_B=opB`. `EX_Dest = RegDst ? ID_Rd : ID_Rt`. Pass through PC, Imm, Rs and Rt.
- A bubble in EX clears `EX_Ctrl.MemRead`, so the hazard self-clears. A load-use stall therefore lasts exactly one cycle.
- `StallCount` increments each cycle `Stall` is 1 and saturates at all-ones. No wrap.
- Register 0 never bypasses and never hazards.

## Timing
- Latency: 1 cycle, ID inputs to EX outputs.
- `Stall` and the bypass mux are same-cycle combinational from ID inputs, WB inputs and EX registers. No registered stall.
- Reset (`RST_N`=0, asynchronous, any time, including mid-stall): all EX outputs 0, `EX_Valid=0`, `StallCount=0`. `Stall` therefore reads 0 while in reset.
- On release, the first posedge with `RST_N=1` captures normally.
- Simultaneous WB write to Rs and load-use hazard: the bubble wins and the bypass result is discarded. On the retry cycle the register file already holds the value.

## Structure
- Shared CPU package holds:
  - `CTRL_W`
  - control-bit index constants (`CTRL_REGWRITE`…`CTRL_ALUOP_LO`)
  - bubble constant `CTRL_NOP = 0`
- One sub-module is natural: `hazard_detect` (pure combinational). Its inputs are the ID specifiers/uses, `EX_Valid`, `EX_Rt`, `EX_Ctrl` MemRead and `Flush`; its output is `Stall`.
- Bypass muxes and pipeline registers stay in `id_ex_stage`.

## Test plan
- Reset mid-stream: assert `RST_N=0` between edges. All EX outputs read 0 immediately, without waiting for a clock edge. `StallCount=0`.
- Bypass: `register1=0x11111111`, `ID_Rs=5`, `WB_RegWrite=1`, `WB_Write=5`, `WB_WriteData=0xDEADBEEF`. Next edge: `EX_A=0xDEADBEEF`. Repeat with `WB_Write=0` and `ID_Rs=0`: `EX_A=register1`.
- Load-use: EX holds `lw` with `EX_Rt=8`; decode `add` with `Rs=8`, `UsesRs=1`. `Stall=1` for exactly one cycle, `EX_Valid=0` next cycle, then the `add` is captured. `StallCount=1`.
- Flush with hazard: same setup plus `Flush=1`. `Stall=0` and a bubble is loaded.
- RegDst: `ID_Rd=3`, `ID_Rt=9`, RegDst=1 gives `EX_Dest=3`. RegDst=0 gives `EX_Dest=9`. `EX_Rt=0` with MemRead never stalls.
- Saturation: force 2^16+3 stall cycles (CNT_W=16). `StallCount` stays at 0xFFFF.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// Shared CPU definitions: control bundle layout and the pipeline bubble encoding.
package id_ex_stage_pkg;

    localparam int unsigned CTRL_W = 10;

    // Control bundle bit positions, MSB first.
    localparam int unsigned CTRL_REGWRITE = 9;
    localparam int unsigned CTRL_MEMREAD  = 8;
    localparam int unsigned CTRL_MEMWRITE = 7;
    localparam int unsigned CTRL_MEMTOREG = 6;
    localparam int unsigned CTRL_ALUSRC   = 5;
    localparam int unsigned CTRL_REGDST   = 4;
    localparam int unsigned CTRL_ALUOP_HI = 3;
    localparam int unsigned CTRL_ALUOP_LO = 0;

    localparam logic [CTRL_W-1:0] CTRL_NOP = '0;

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-slot inputs, writeback bypass inputs and EX-stage outputs of the ID/EX register.
interface id_ex_stage_if #(
    parameter int unsigned CTRL_W = 10,
    parameter int unsigned CNT_W  = 16
);
    logic              ID_Valid;
    logic [31:0]       ID_PC;
    logic [4:0]        ID_Rs;
    logic [4:0]        ID_Rt;
    logic [4:0]        ID_Rd;
    logic              ID_UsesRs;
    logic              ID_UsesRt;
    logic [31:0]       ID_Imm;
    logic [CTRL_W-1:0] ID_Ctrl;
    logic [31:0]       register1;
    logic [31:0]       register2;
    logic              WB_RegWrite;
    logic [4:0]        WB_Write;
    logic [31:0]       WB_WriteData;
    logic              Flush;
    logic              Stall;
    logic              EX_Valid;
    logic [31:0]       EX_PC;
    logic [31:0]       EX_A;
    logic [31:0]       EX_B;
    logic [31:0]       EX_Imm;
    logic [4:0]        EX_Rs;
    logic [4:0]        EX_Rt;
    logic [4:0]        EX_Dest;
    logic [CTRL_W-1:0] EX_Ctrl;
    logic [CNT_W-1:0]  StallCount;

    modport master (
        output ID_Valid, ID_PC, ID_Rs, ID_Rt, ID_Rd, ID_UsesRs, ID_UsesRt, ID_Imm, ID_Ctrl,
        output register1, register2, WB_RegWrite, WB_Write, WB_WriteData, Flush,
        input  Stall, EX_Valid, EX_PC, EX_A, EX_B, EX_Imm, EX_Rs, EX_Rt, EX_Dest, EX_Ctrl,
        input  StallCount
    );

    modport slave (
        input  ID_Valid, ID_PC, ID_Rs, ID_Rt, ID_Rd, ID_UsesRs, ID_UsesRt, ID_Imm, ID_Ctrl,
        input  register1, register2, WB_RegWrite, WB_Write, WB_WriteData, Flush,
        output Stall, EX_Valid, EX_PC, EX_A, EX_B, EX_Imm, EX_Rs, EX_Rt, EX_Dest, EX_Ctrl,
        output StallCount
    );

endinterface

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detection: stall when decode reads the register a load in EX will write.
module hazard_detect (
    input  logic       i_id_valid,
    input  logic [4:0] i_id_rs,
    input  logic [4:0] i_id_rt,
    input  logic       i_uses_rs,
    input  logic       i_uses_rt,
    input  logic       i_ex_valid,
    input  logic [4:0] i_ex_rt,
    input  logic       i_ex_memread,
    input  logic       i_flush,
    output logic       o_stall
);

    logic w_rs_match;
    logic w_rt_match;
    logic w_haz;

    assign w_rs_match = i_uses_rs && (i_id_rs == i_ex_rt);
    assign w_rt_match = i_uses_rt && (i_id_rt == i_ex_rt);
    assign w_haz      = i_id_valid && i_ex_valid && i_ex_memread && (i_ex_rt != 5'd0) &&
                        (w_rs_match || w_rt_match);
    // A flushed instruction is discarded anyway, so holding the front end is pointless.
    assign o_stall    = w_haz && !i_flush;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with writeback bypass, load-use bubble insertion and stall counter.
module id_ex_stage #(
    parameter int unsigned CTRL_W = id_ex_stage_pkg::CTRL_W,
    parameter int unsigned CNT_W  = 16
) (
    input  logic            CLK,
    input  logic            RST_N,
    id_ex_stage_if.slave    bus
);
    import id_ex_stage_pkg::*;

    logic              r_ex_valid;
    logic [31:0]       r_ex_pc;
    logic [31:0]       r_ex_a;
    logic [31:0]       r_ex_b;
    logic [31:0]       r_ex_imm;
    logic [4:0]        r_ex_rs;
    logic [4:0]        r_ex_rt;
    logic [4:0]        r_ex_dest;
    logic [CTRL_W-1:0] r_ex_ctrl;
    logic [CNT_W-1:0]  r_stall_cnt;

    logic              w_stall;
    logic              w_bubble;
    logic [31:0]       w_op_a;
    logic [31:0]       w_op_b;
    logic [CTRL_W-1:0] w_ctrl_next;
    logic [4:0]        w_dest_next;

    hazard_detect u_hazard_detect (
        .i_id_valid   (bus.ID_Valid),
        .i_id_rs      (bus.ID_Rs),
        .i_id_rt      (bus.ID_Rt),
        .i_uses_rs    (bus.ID_UsesRs),
        .i_uses_rt    (bus.ID_UsesRt),
        .i_ex_valid   (r_ex_valid),
        .i_ex_rt      (r_ex_rt),
        .i_ex_memread (r_ex_ctrl[CTRL_MEMREAD]),
        .i_flush      (bus.Flush),
        .o_stall      (w_stall)
    );

    // Register file reads the old value on a same-cycle write, so forward WB data here.
    assign w_op_a = (bus.WB_RegWrite && bus.WB_Write != 5'd0 && bus.WB_Write == bus.ID_Rs) ?
                    bus.WB_WriteData : bus.register1;
    assign w_op_b = (bus.WB_RegWrite && bus.WB_Write != 5'd0 && bus.WB_Write == bus.ID_Rt) ?
                    bus.WB_WriteData : bus.register2;

    // Flush || haz reduces to Flush || Stall since Stall is haz masked by Flush.
    assign w_bubble    = bus.Flush || w_stall;
    assign w_ctrl_next = bus.ID_Valid ? bus.ID_Ctrl : CTRL_W'(CTRL_NOP);
    assign w_dest_next = bus.ID_Ctrl[CTRL_REGDST] ? bus.ID_Rd : bus.ID_Rt;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_ex_valid  <= 1'b0;
            r_ex_pc     <= '0;
            r_ex_a      <= '0;
            r_ex_b      <= '0;
            r_ex_imm    <= '0;
            r_ex_rs     <= '0;
            r_ex_rt     <= '0;
            r_ex_dest   <= '0;
            r_ex_ctrl   <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_bubble) begin
                r_ex_valid <= 1'b0;
                r_ex_pc    <= '0;
                r_ex_a     <= '0;
                r_ex_b     <= '0;
                r_ex_imm   <= '0;
                r_ex_rs    <= '0;
                r_ex_rt    <= '0;
                r_ex_dest  <= '0;
                r_ex_ctrl  <= CTRL_W'(CTRL_NOP);
            end else begin
                r_ex_valid <= bus.ID_Valid;
                r_ex_pc    <= bus.ID_PC;
                r_ex_a     <= w_op_a;
                r_ex_b     <= w_op_b;
                r_ex_imm   <= bus.ID_Imm;
                r_ex_rs    <= bus.ID_Rs;
                r_ex_rt    <= bus.ID_Rt;
                r_ex_dest  <= w_dest_next;
                r_ex_ctrl  <= w_ctrl_next;
            end
            if (w_stall && r_stall_cnt != '1) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.Stall      = w_stall;
    assign bus.EX_Valid   = r_ex_valid;
    assign bus.EX_PC      = r_ex_pc;
    assign bus.EX_A       = r_ex_a;
    assign bus.EX_B       = r_ex_b;
    assign bus.EX_Imm     = r_ex_imm;
    assign bus.EX_Rs      = r_ex_rs;
    assign bus.EX_Rt      = r_ex_rt;
    assign bus.EX_Dest    = r_ex_dest;
    assign bus.EX_Ctrl    = r_ex_ctrl;
    assign bus.StallCount = r_stall_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: bypass, load-use stall, flush, RegDst, reset and saturation.
module tb_id_ex_stage;

    localparam int unsigned CTRL_W = 10;
    // Narrow counter so saturation is reachable: stalls occur at most every other cycle.
    localparam int unsigned CNT_W  = 4;

    localparam logic [CTRL_W-1:0] CTRL_LW  = 10'h360; // RegWrite MemRead MemToReg ALUSrc
    localparam logic [CTRL_W-1:0] CTRL_ADD = 10'h212; // RegWrite RegDst ALUOp=2

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_fail;
    int   n_stalls;

    id_ex_stage_if #(.CTRL_W(CTRL_W), .CNT_W(CNT_W)) u_if ();

    id_ex_stage #(.CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic valid, input logic [31:0] pc, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] rd, input logic urs,
                         input logic urt, input logic [CTRL_W-1:0] ctrl);
        u_if.ID_Valid  = valid;
        u_if.ID_PC     = pc;
        u_if.ID_Rs     = rs;
        u_if.ID_Rt     = rt;
        u_if.ID_Rd     = rd;
        u_if.ID_UsesRs = urs;
        u_if.ID_UsesRt = urt;
        u_if.ID_Imm    = pc ^ 32'h0000_FFFF;
        u_if.ID_Ctrl   = ctrl;
    endtask

    task automatic wb(input logic we, input logic [4:0] addr, input logic [31:0] data);
        u_if.WB_RegWrite  = we;
        u_if.WB_Write     = addr;
        u_if.WB_WriteData = data;
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        n_stalls = 0;
        rst_n = 1'b0;
        drive(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, '0);
        wb(1'b0, 5'd0, 32'h0);
        u_if.register1 = 32'h1111_1111;
        u_if.register2 = 32'h2222_2222;
        u_if.Flush = 1'b0;
        #12;
        check("reset_valid", 64'(u_if.EX_Valid), 64'h0);
        check("reset_ctrl", 64'(u_if.EX_Ctrl), 64'h0);
        check("reset_cnt", 64'(u_if.StallCount), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Bypass of Rs from writeback.
        drive(1'b1, 32'h100, 5'd5, 5'd6, 5'd3, 1'b1, 1'b1, CTRL_ADD);
        wb(1'b1, 5'd5, 32'hDEAD_BEEF);
        step();
        check("byp_a", 64'(u_if.EX_A), 64'hDEAD_BEEF);
        check("byp_b_nobyp", 64'(u_if.EX_B), 64'h2222_2222);
        check("byp_valid", 64'(u_if.EX_Valid), 64'h1);
        check("byp_ctrl", 64'(u_if.EX_Ctrl), 64'(CTRL_ADD));
        check("byp_pc", 64'(u_if.EX_PC), 64'h100);
        check("byp_imm", 64'(u_if.EX_Imm), 64'h0000_FEFF);
        check("regdst1", 64'(u_if.EX_Dest), 64'd3);

        // Register 0 never bypasses.
        drive(1'b1, 32'h104, 5'd0, 5'd6, 5'd3, 1'b1, 1'b1, CTRL_ADD);
        wb(1'b1, 5'd0, 32'hDEAD_BEEF);
        step();
        check("r0_nobyp", 64'(u_if.EX_A), 64'h1111_1111);

        // Bypass of Rt.
        drive(1'b1, 32'h108, 5'd5, 5'd6, 5'd3, 1'b1, 1'b1, CTRL_ADD);
        wb(1'b1, 5'd6, 32'hCAFE_F00D);
        step();
        check("rt_byp_b", 64'(u_if.EX_B), 64'hCAFE_F00D);
        check("rt_byp_a", 64'(u_if.EX_A), 64'h1111_1111);
        wb(1'b0, 5'd0, 32'h0);

        // RegDst=0 picks Rt; this lw (Rt=9) sits in EX afterwards.
        drive(1'b1, 32'h10C, 5'd1, 5'd9, 5'd3, 1'b1, 1'b0, CTRL_LW);
        step();
        check("regdst0", 64'(u_if.EX_Dest), 64'd9);

        // Load-use: lw Rt=8, then add Rs=8.
        drive(1'b1, 32'h110, 5'd1, 5'd8, 5'd0, 1'b1, 1'b0, CTRL_LW);
        step();
        check("lu_nostall_pre", 64'(u_if.Stall), 64'h0);
        drive(1'b1, 32'h114, 5'd8, 5'd2, 5'd4, 1'b1, 1'b1, CTRL_ADD);
        #1;
        check("lu_stall", 64'(u_if.Stall), 64'h1);
        step();
        check("lu_bubble_valid", 64'(u_if.EX_Valid), 64'h0);
        check("lu_bubble_ctrl", 64'(u_if.EX_Ctrl), 64'h0);
        check("lu_bubble_pc", 64'(u_if.EX_PC), 64'h0);
        check("lu_stall_clear", 64'(u_if.Stall), 64'h0);
        check("lu_cnt", 64'(u_if.StallCount), 64'd1);
        step();
        check("lu_retry_valid", 64'(u_if.EX_Valid), 64'h1);
        check("lu_retry_rs", 64'(u_if.EX_Rs), 64'd8);
        check("lu_retry_pc", 64'(u_if.EX_PC), 64'h114);
        check("lu_cnt_hold", 64'(u_if.StallCount), 64'd1);

        // Flush with hazard: no stall, bubble loaded.
        drive(1'b1, 32'h118, 5'd1, 5'd8, 5'd0, 1'b1, 1'b0, CTRL_LW);
        step();
        drive(1'b1, 32'h11C, 5'd8, 5'd2, 5'd4, 1'b1, 1'b1, CTRL_ADD);
        u_if.Flush = 1'b1;
        #1;
        check("fl_stall", 64'(u_if.Stall), 64'h0);
        step();
        u_if.Flush = 1'b0;
        check("fl_bubble_valid", 64'(u_if.EX_Valid), 64'h0);
        check("fl_bubble_pc", 64'(u_if.EX_PC), 64'h0);
        check("fl_cnt", 64'(u_if.StallCount), 64'd1);

        // Load to r0 never hazards.
        drive(1'b1, 32'h120, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0, CTRL_LW);
        step();
        drive(1'b1, 32'h124, 5'd0, 5'd0, 5'd4, 1'b1, 1'b1, CTRL_ADD);
        #1;
        check("r0_nostall", 64'(u_if.Stall), 64'h0);
        step();
        check("r0_captured", 64'(u_if.EX_Valid), 64'h1);

        // Hazard plus same-cycle WB to Rs: bubble wins, retry reads the register file.
        drive(1'b1, 32'h128, 5'd1, 5'd8, 5'd0, 1'b1, 1'b0, CTRL_LW);
        step();
        drive(1'b1, 32'h12C, 5'd8, 5'd2, 5'd4, 1'b1, 1'b1, CTRL_ADD);
        wb(1'b1, 5'd8, 32'h5555_AAAA);
        step();
        check("hzwb_bubble_a", 64'(u_if.EX_A), 64'h0);
        wb(1'b0, 5'd0, 32'h0);
        u_if.register1 = 32'h5555_AAAA;
        step();
        check("hzwb_retry_a", 64'(u_if.EX_A), 64'h5555_AAAA);
        check("hzwb_cnt", 64'(u_if.StallCount), 64'd2);
        u_if.register1 = 32'h1111_1111;

        // Asynchronous reset in the middle of a stall.
        drive(1'b1, 32'h130, 5'd1, 5'd8, 5'd0, 1'b1, 1'b0, CTRL_LW);
        step();
        drive(1'b1, 32'h134, 5'd8, 5'd2, 5'd4, 1'b1, 1'b1, CTRL_ADD);
        #2;
        check("mr_stall_pre", 64'(u_if.Stall), 64'h1);
        rst_n = 1'b0;
        #1;
        check("mr_valid", 64'(u_if.EX_Valid), 64'h0);
        check("mr_pc", 64'(u_if.EX_PC), 64'h0);
        check("mr_rt", 64'(u_if.EX_Rt), 64'h0);
        check("mr_ctrl", 64'(u_if.EX_Ctrl), 64'h0);
        check("mr_stall", 64'(u_if.Stall), 64'h0);
        check("mr_cnt", 64'(u_if.StallCount), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("post_rst_capture", 64'(u_if.EX_PC), 64'h134);

        // Saturation: a lw whose Rs equals its own Rt stalls on every other cycle.
        rst_n = 1'b0;
        #1;
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 32'h200, 5'd8, 5'd8, 5'd0, 1'b1, 1'b0, CTRL_LW);
        step();
        for (int i = 0; i < 2 * ((1 << CNT_W) + 3); i++) begin
            if (u_if.Stall === 1'b1) n_stalls++;
            step();
            if (n_stalls == 5 && u_if.Stall === 1'b0 && u_if.EX_Valid === 1'b0) begin
                check("sat_mid", 64'(u_if.StallCount), 64'd5);
            end
        end
        check("sat_stalls_seen", 64'(n_stalls), 64'((1 << CNT_W) + 3));
        check("sat_cnt", 64'(u_if.StallCount), 64'((1 << CNT_W) - 1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
